// File: rtl/actor_write_buffer.sv
// Actor write buffer: turns decoded actor commands into FIFO entries that drain to the actor bus over valid/ready.
// Optional drop counter output DROP_CNT_O is built only when ACTOR_WRITE_BUFFER_DROP_CNT_EN is defined.
module actor_write_buffer #(
    parameter int ACTOR_ID_WIDTH = 8,
    parameter int PE_ID_WIDTH    = 4,
    parameter int PE_COUNT       = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                           CGRA_CLK_I,
    input  logic                           RST_N_I,
    input  logic                           EN_I,
    input  logic [ACTOR_ID_WIDTH-1:0]      ACTOR_WRITE_ADDR_I,
    input  logic [PE_ID_WIDTH-1:0]         ACTOR_SOURCE_PE_ID_I,
    input  logic                           ACTOR_WRITE_ENABLE_I,
    input  logic                           SYNC_IN_I,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] PE_DATA_I,
    output logic                           M_VALID_O,
    input  logic                           M_READY_I,
    output logic [ACTOR_ID_WIDTH-1:0]      M_ACTOR_ID_O,
    output logic [DATA_WIDTH-1:0]          M_DATA_O,
    output logic                           M_LAST_O,
    output logic                           M_NOP_O,
    output logic                           FULL_O,
    output logic                           OVERFLOW_O,
`ifdef ACTOR_WRITE_BUFFER_DROP_CNT_EN
    output logic [15:0]                    DROP_CNT_O,
`endif
    input  logic                           CLEAR_I
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [ACTOR_ID_WIDTH-1:0] id_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem [FIFO_DEPTH];
    logic                      last_mem [FIFO_DEPTH];
    logic                      nop_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             ovf_q;

    logic                      push_req;
    logic                      push_ok;
    logic                      pop;
    logic                      drop;
    logic                      fifo_full;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [ACTOR_ID_WIDTH-1:0] ent_id;
    logic [DATA_WIDTH-1:0]     ent_data;
    logic                      ent_last;
    logic                      ent_nop;

    // IDs at or above PE_COUNT match no slot and fall through to zero
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (ACTOR_SOURCE_PE_ID_I == i[PE_ID_WIDTH-1:0]) begin
                sel_data = PE_DATA_I[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ent_id   = '0;
        ent_data = '0;
        ent_last = 1'b1;
        ent_nop  = 1'b1;
        if (ACTOR_WRITE_ENABLE_I) begin
            ent_id   = ACTOR_WRITE_ADDR_I;
            ent_data = sel_data;
            ent_last = SYNC_IN_I;
            ent_nop  = 1'b0;
        end
    end

    assign fifo_full = (count == DEPTH_CNT);
    assign pop       = (count != '0) && M_READY_I;
    assign push_req  = EN_I && (ACTOR_WRITE_ENABLE_I || SYNC_IN_I) && !CLEAR_I;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset: everything read out is qualified by the occupancy count
    always_ff @(posedge CGRA_CLK_I) begin
        if (push_ok) begin
            id_mem[wr_ptr]   <= ent_id;
            data_mem[wr_ptr] <= ent_data;
            last_mem[wr_ptr] <= ent_last;
            nop_mem[wr_ptr]  <= ent_nop;
        end
    end

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (CLEAR_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_nxt;
            full_q <= (count_nxt == DEPTH_CNT);
            if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef ACTOR_WRITE_BUFFER_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            drop_cnt <= '0;
        end else if (CLEAR_I) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign DROP_CNT_O = drop_cnt;
`endif

    assign M_VALID_O    = (count != '0);
    assign M_ACTOR_ID_O = M_VALID_O ? id_mem[rd_ptr]   : '0;
    assign M_DATA_O     = M_VALID_O ? data_mem[rd_ptr] : '0;
    assign M_LAST_O     = M_VALID_O && last_mem[rd_ptr];
    assign M_NOP_O      = M_VALID_O && nop_mem[rd_ptr];
    assign FULL_O       = full_q;
    assign OVERFLOW_O   = ovf_q;

endmodule

// File: tb/tb_actor_write_buffer.sv
// Bench for actor_write_buffer: queue-based reference model with a decoupled output monitor.
// Built with PE_COUNT=12 so out-of-range PE IDs can be exercised.
module tb_actor_write_buffer;

    localparam int PE_CNT = 12;
    localparam int DEPTH  = 8;
    localparam int DW     = 32;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
        logic        nop;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [7:0]        addr = '0;
    logic [3:0]        pe = '0;
    logic              we = 1'b0;
    logic              sync = 1'b0;
    logic [PE_CNT*DW-1:0] pe_data = '0;
    logic              rdy = 1'b0;
    logic              clr = 1'b0;
    logic              m_valid;
    logic [7:0]        m_id;
    logic [31:0]       m_data;
    logic              m_last;
    logic              m_nop;
    logic              full;
    logic              ovf;
    logic [15:0]       drop_cnt;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];
    int   occ   = 0;
    bit   m_ovf = 0;
    int   m_drop = 0;

    always #5 clk = ~clk;

    actor_write_buffer #(
        .ACTOR_ID_WIDTH(8), .PE_ID_WIDTH(4), .PE_COUNT(PE_CNT),
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CGRA_CLK_I(clk),
        .RST_N_I(rst_n),
        .EN_I(en),
        .ACTOR_WRITE_ADDR_I(addr),
        .ACTOR_SOURCE_PE_ID_I(pe),
        .ACTOR_WRITE_ENABLE_I(we),
        .SYNC_IN_I(sync),
        .PE_DATA_I(pe_data),
        .M_VALID_O(m_valid),
        .M_READY_I(rdy),
        .M_ACTOR_ID_O(m_id),
        .M_DATA_O(m_data),
        .M_LAST_O(m_last),
        .M_NOP_O(m_nop),
        .FULL_O(full),
        .OVERFLOW_O(ovf),
`ifdef ACTOR_WRITE_BUFFER_DROP_CNT_EN
        .DROP_CNT_O(drop_cnt),
`endif
        .CLEAR_I(clr)
    );

`ifndef ACTOR_WRITE_BUFFER_DROP_CNT_EN
    assign drop_cnt = '0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t expect_entry(input bit w, input bit s, input logic [7:0] a,
                                          input logic [3:0] p, input logic [PE_CNT*DW-1:0] d);
        ent_t e;
        if (w) begin
            e.id   = a;
            e.data = (int'(p) < PE_CNT) ? d[int'(p)*DW +: DW] : 32'd0;
            e.last = s;
            e.nop  = 1'b0;
        end else begin
            e.id = '0; e.data = '0; e.last = 1'b1; e.nop = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        occ    = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    // Reference model: FIFO occupancy and drop rules evaluated at each active edge
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else if (clr) begin
                model_reset();
            end else begin
                bit was_full;
                bit popping;
                was_full = (occ == DEPTH);
                popping  = (occ > 0) && rdy;
                if (popping) occ--;
                if (en && (we || sync)) begin
                    if (!was_full || popping) begin
                        exp_q.push_back(expect_entry(we, sync, addr, pe, pe_data));
                        occ++;
                    end else begin
                        m_ovf = 1;
                        if (m_drop < 16'hFFFF) m_drop++;
                    end
                end
            end
        end
    end

    // Monitor: compares the presented head and status against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid", 64'(m_valid), 64'(exp_q.size() != 0));
                if (m_valid && exp_q.size() != 0) begin
                    chk("head_id",   64'(m_id),   64'(exp_q[0].id));
                    chk("head_data", 64'(m_data), 64'(exp_q[0].data));
                    chk("head_last", 64'(m_last), 64'(exp_q[0].last));
                    chk("head_nop",  64'(m_nop),  64'(exp_q[0].nop));
                    if (rdy) void'(exp_q.pop_front());
                end
                chk("full",     64'(full), 64'(occ == DEPTH));
                chk("overflow", 64'(ovf),  64'(m_ovf));
`ifdef ACTOR_WRITE_BUFFER_DROP_CNT_EN
                chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
            end
        end
    end

    task automatic step(input bit e, input bit w, input bit s, input logic [7:0] a,
                        input logic [3:0] p, input logic [31:0] word, input bit r, input bit c);
        for (int k = 0; k < PE_CNT; k++) pe_data[k*DW +: DW] = $urandom;
        if (int'(p) < PE_CNT) pe_data[int'(p)*DW +: DW] = word;
        en = e; we = w; sync = s; addr = a; pe = p; rdy = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(0, 0, 0, 8'h00, 4'd0, 32'h0, r, 0);
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_id",    64'(m_id),    64'd0);
        chk("rst_data",  64'(m_data),  64'd0);
        chk("rst_last",  64'(m_last),  64'd0);
        chk("rst_nop",   64'(m_nop),   64'd0);
        chk("rst_full",  64'(full),    64'd0);
        chk("rst_ovf",   64'(ovf),     64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single write, visible for exactly one cycle
        step(1, 1, 0, 8'h05, 4'd3, 32'hDEADBEEF, 1, 0);
        chk("single_valid", 64'(m_valid), 64'd1);
        chk("single_id",    64'(m_id),    64'h05);
        chk("single_data",  64'(m_data),  64'hDEADBEEF);
        chk("single_last",  64'(m_last),  64'd0);
        chk("single_nop",   64'(m_nop),   64'd0);
        idle(1);
        chk("single_gone", 64'(m_valid), 64'd0);

        // sync-only marker, then write with sync
        step(1, 0, 1, 8'hAA, 4'd2, 32'h1234, 1, 0);
        chk("sync_nop",  64'(m_nop),  64'd1);
        chk("sync_last", 64'(m_last), 64'd1);
        chk("sync_data", 64'(m_data), 64'd0);
        step(1, 1, 1, 8'h21, 4'd1, 32'hCAFE0001, 1, 0);
        chk("wsync_last", 64'(m_last), 64'd1);
        chk("wsync_nop",  64'(m_nop),  64'd0);
        idle(1);

        // back-pressure fill, overflow, ordered drain
        for (int i = 1; i <= DEPTH; i++) step(1, 1, 0, 8'(i), 4'd0, 32'(i), 0, 0);
        chk("bp_full", 64'(full), 64'd1);
        chk("bp_ovf0", 64'(ovf),  64'd0);
        step(1, 1, 0, 8'h09, 4'd0, 32'h9, 0, 0);
        chk("bp_ovf1", 64'(ovf), 64'd1);
`ifdef ACTOR_WRITE_BUFFER_DROP_CNT_EN
        chk("bp_drop1", 64'(drop_cnt), 64'd1);
`endif
        for (int i = 0; i < DEPTH + 2; i++) idle(1);
        chk("bp_empty", 64'(m_valid), 64'd0);
        step(0, 0, 0, 8'h0, 4'd0, 32'h0, 0, 1);
        chk("clr_ovf", 64'(ovf), 64'd0);

        // full with concurrent pop
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 8'h40, 4'd5, 32'h10 + 32'(i), 0, 0);
        step(1, 1, 0, 8'h41, 4'd5, 32'h99, 1, 0);
        chk("fpop_ovf",  64'(ovf),  64'd0);
        chk("fpop_full", 64'(full), 64'd1);
        for (int i = 0; i < DEPTH + 2; i++) idle(1);

        // out-of-range PE and enable gating
        step(1, 1, 0, 8'h33, 4'd14, 32'hFFFF_FFFF, 1, 0);
        chk("oor_valid", 64'(m_valid), 64'd1);
        chk("oor_data",  64'(m_data),  64'd0);
        idle(1);
        step(0, 1, 1, 8'h34, 4'd1, 32'h5555, 1, 0);
        chk("en_gate", 64'(m_valid), 64'd0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h50, 4'd2, 32'(i), 0, 0);
        en = 0; we = 0; sync = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_data",  64'(m_data),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // synchronous clear mid-stream, with overflow set and a push discarded
        for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 0, 8'h60, 4'd3, 32'(i), 0, 0);
        chk("pre_clr_ovf", 64'(ovf), 64'd1);
        step(1, 1, 0, 8'h61, 4'd3, 32'h77, 0, 1);
        chk("clr_valid", 64'(m_valid), 64'd0);
        chk("clr_ovf2",  64'(ovf),     64'd0);
        chk("clr_full",  64'(full),    64'd0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) == 0), 8'($urandom), 4'($urandom),
                 $urandom, 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) == 0));
        end

        // bounded final drain
        begin
            int budget;
            budget = 0;
            while (m_valid && budget < 4 * DEPTH) begin
                idle(1);
                budget++;
            end
            chk("drain_done", 64'(m_valid), 64'd0);
            chk("drain_model", 64'(exp_q.size()), 64'd0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/actor_write_buffer.md
# actor_write_buffer

Downstream stage of the actor context interface: each enabled CGRA cycle it takes the decoded actor command (target actor ID, source PE ID, write enable, sync), selects the addressed PE's output word, and pushes an entry into a small FIFO. The FIFO drains to the actor bus over a valid/ready handshake, decoupling CGRA context timing from actor back-pressure. Overflow is flagged and sticky, never silently ignored.

## Interface
- ACTOR_ID_WIDTH, 8, width of the actor address field
- PE_ID_WIDTH, 4, width of the source PE ID
- PE_COUNT, 16, number of PE outputs presented on PE_DATA_I (≤ 2^PE_ID_WIDTH)
- DATA_WIDTH, 32, PE output word width
- FIFO_DEPTH, 8, entries; power of two, ≥ 2

Ports:
- CGRA_CLK_I  in  1  clock; all logic on rising edge
- RST_N_I  in  1  asynchronous, active-low reset
- EN_I  in  1  CGRA enable; inputs sampled only when high
- ACTOR_WRITE_ADDR_I  in  ACTOR_ID_WIDTH  target actor ID
- ACTOR_SOURCE_PE_ID_I  in  PE_ID_WIDTH  PE whose output is written
- ACTOR_WRITE_ENABLE_I  in  1  request a write this cycle
- SYNC_IN_I  in  1  end-of-batch marker
- PE_DATA_I  in  PE_COUNT*DATA_WIDTH  concatenated PE outputs, PE n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- M_VALID_O  out  1  head entry valid
- M_READY_I  in  1  consumer accepts head entry
- M_ACTOR_ID_O  out  ACTOR_ID_WIDTH  head actor ID
- M_DATA_O  out  DATA_WIDTH  head data
- M_LAST_O  out  1  head entry closes a batch
- M_NOP_O  out  1  head is a sync-only marker (no actor write)
- FULL_O  out  1  FIFO holds FIFO_DEPTH entries
- OVERFLOW_O  out  1  sticky: a push was dropped
- CLEAR_I  in  1  synchronous clear of OVERFLOW_O and the FIFO

## Operation
- Push condition (EN_I=1): WE=1 → entry {actor ID, selected data, last=SYNC_IN_I, nop=0}; WE=0 and SYNC_IN_I=1 → entry {0, 0, last=1, nop=1}; otherwise no push.
- Data select: PE_DATA_I slice for ACTOR_SOURCE_PE_ID_I; ID ≥ PE_COUNT selects 0.
- EN_I=0: no push; draining continues independent of EN_I.
- Pop: M_VALID_O && M_READY_I pops head.
- Full: push accepted if a pop happens in the same cycle; otherwise dropped and OVERFLOW_O set.
- Empty: simultaneous push and pop impossible (M_VALID_O=0); push stored normally.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- CLEAR_I: next edge empties FIFO and clears OVERFLOW_O; any push in that cycle is discarded. CLEAR_I has priority over push and pop.
- Reset mid-operation: all entries lost, pointers and count zeroed immediately (asynchronous).

## Timing
- Reset values: M_VALID_O=0, M_ACTOR_ID_O=0, M_DATA_O=0, M_LAST_O=0, M_NOP_O=0, FULL_O=0, OVERFLOW_O=0.
- Push-to-valid latency: 1 cycle (entry visible on M_* the cycle after the push edge).
- M_* outputs stay stable while M_VALID_O=1 and M_READY_I=0.
- FULL_O and OVERFLOW_O are registered; FULL_O updates the cycle after the push that fills the FIFO.
- Throughput: one push and one pop per cycle.

## Configuration
- ACTOR_WRITE_BUFFER_DROP_CNT_EN defined: adds output DROP_CNT_O [15:0], incremented per dropped push, saturating at 0xFFFF, cleared by reset and CLEAR_I.
- Undefined: port and counter absent; OVERFLOW_O is the only drop indication.

## Test plan
- Single write: EN=1, WE=1, actor 0x05, PE 3, PE3 data 0xDEADBEEF, READY=1 → next cycle VALID=1, ID=0x05, DATA=0xDEADBEEF, LAST=0, NOP=0 for one cycle.
- Sync-only: WE=0, SYNC=1 → one entry ID=0, DATA=0, LAST=1, NOP=1; WE=1 with SYNC=1 → LAST=1, NOP=0.
- Back-pressure: READY=0, 8 writes with data 1..8 → FULL_O=1, OVERFLOW_O=0; 9th write → OVERFLOW_O=1 (DROP_CNT_O=1 if enabled); READY=1 → drains 1..8 in order, nothing else.
- Full with concurrent pop: FIFO full, READY=1, push data 0x99 → no overflow, 0x99 emerges eighth after the popped head.
- Out-of-range PE / EN gating: PE_COUNT=12, PE ID 14 → DATA=0; EN_I=0 with WE=1 → no entry.
- Reset/clear mid-stream: 4 entries queued, RST_N_I low for a partial cycle → VALID=0 immediately; repeat with CLEAR_I=1 → VALID=0 and OVERFLOW_O=0 next cycle.
